// File: rtl/conv_ctrl_pkg.sv
// Shared encodings for the conv accelerator feed controller:
// FSM states, PIO command bit positions and status word layout.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int CMD_PIX_LSB   = 0;
    localparam int CMD_WR_BIT    = 8;
    localparam int CMD_START_BIT = 9;
    localparam int CMD_ABORT_BIT = 10;

    localparam int ST_STATE_LSB = 0;
    localparam int ST_PIX_LSB   = 3;
    localparam int ST_RES_LSB   = 13;
    localparam int ST_DONE_BIT  = 23;
    localparam int ST_UNEXP_BIT = 24;
    localparam int ST_EXTRA_BIT = 25;
    localparam int ST_TMO_BIT   = 26;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [15:0]      TMO_MAX = 16'hFFFF;

    function automatic logic [31:0] pack_status(
        input state_e           st,
        input logic [CNT_W-1:0] pix,
        input logic [CNT_W-1:0] res,
        input logic             done,
        input logic             unexp,
        input logic             extra,
        input logic             tmo
    );
        logic [31:0] s;
        s = '0;
        s[ST_STATE_LSB +: 3]   = st;
        s[ST_PIX_LSB +: CNT_W] = pix;
        s[ST_RES_LSB +: CNT_W] = res;
        s[ST_DONE_BIT]         = done;
        s[ST_UNEXP_BIT]        = unexp;
        s[ST_EXTRA_BIT]        = extra;
        s[ST_TMO_BIT]          = tmo;
        return s;
    endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Level-change detector: flags a cycle whose input differs
// from the value registered on the previous cycle.
module toggle_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic tgl_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign tgl_o = d_i ^ d_q;

endmodule

// File: rtl/conv_feed_ctrl.sv
// Pixel feed controller between a CPU PIO word and a conv accelerator.
// Define CONV_FEED_CTRL_TIMEOUT_EN to enable the DRAIN idle timeout.
module conv_feed_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int RES_CNT = 676,
    parameter int CLR_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] cmd_in,
    output logic        acc_rst_n,
    output logic        acc_valid,
    output logic [7:0]  acc_pixel,
    input  logic [31:0] acc_res,
    input  logic        acc_res_valid,
    output logic [31:0] res_data,
    output logic [31:0] status
);

    localparam int PIX_TOT = IMG_W * IMG_H;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOT - 1);
    localparam logic [CNT_W-1:0] RES_TGT  = CNT_W'(RES_CNT);
    localparam logic [7:0]       CLR_LAST = 8'(CLR_CYC - 1);

    state_e           state_q, state_d;
    logic [7:0]       clr_q, clr_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] res_inc;
    logic             done_q, done_d;
    logic             unexp_q, unexp_d;
    logic             extra_q, extra_d;
    logic             vld_q, vld_d;
    logic [7:0]       pixel_q, pixel_d;
    logic [31:0]      data_q, data_d;
    logic             arst_q, arst_d;
    logic             tmo_flag;

    logic start_tgl;
    logic wr_tgl;
    logic abort;
    logic unused_cmd;

`ifdef CONV_FEED_CTRL_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_err_q, tmo_err_d;
    assign tmo_flag = tmo_err_q;
`else
    assign tmo_flag = 1'b0;
`endif

    toggle_edge_det u_start_det (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (cmd_in[CMD_START_BIT]),
        .tgl_o  (start_tgl)
    );

    toggle_edge_det u_wr_det (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (cmd_in[CMD_WR_BIT]),
        .tgl_o  (wr_tgl)
    );

    assign abort      = cmd_in[CMD_ABORT_BIT];
    assign unused_cmd = ^cmd_in[31:CMD_ABORT_BIT+1];
    assign res_inc    = (res_q == CNT_MAX) ? res_q : res_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        clr_d   = '0;
        pix_d   = pix_q;
        res_d   = res_q;
        done_d  = done_q;
        unexp_d = unexp_q;
        extra_d = extra_q;
        vld_d   = 1'b0;
        pixel_d = pixel_q;
        data_d  = data_q;
`ifdef CONV_FEED_CTRL_TIMEOUT_EN
        tmo_d     = '0;
        tmo_err_d = tmo_err_q;
`endif

        if (wr_tgl && state_q != S_LOAD) begin
            unexp_d = 1'b1;
        end

        if (acc_res_valid) begin
            if (state_q == S_LOAD || state_q == S_DRAIN) begin
                data_d = acc_res;
                res_d  = res_inc;
            end else if (state_q == S_IDLE || state_q == S_DONE) begin
                extra_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_tgl) begin
                    state_d = S_CLEAR;
                    pix_d   = '0;
                    res_d   = '0;
                    done_d  = 1'b0;
                    unexp_d = 1'b0;
                    extra_d = 1'b0;
`ifdef CONV_FEED_CTRL_TIMEOUT_EN
                    tmo_err_d = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + 8'd1;
                if (clr_q == CLR_LAST) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_tgl) begin
                    vld_d   = 1'b1;
                    pixel_d = cmd_in[CMD_PIX_LSB +: 8];
                    pix_d   = pix_q + CNT_ONE;
                    if (pix_q == PIX_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (res_d >= RES_TGT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef CONV_FEED_CTRL_TIMEOUT_EN
                else begin
                    tmo_d = acc_res_valid ? 16'd0 : tmo_q + 16'd1;
                    if (tmo_d == TMO_MAX) begin
                        tmo_err_d = 1'b1;
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes all bookkeeping so the CPU can inspect it
        if (abort) begin
            state_d = S_IDLE;
            clr_d   = '0;
            pix_d   = pix_q;
            res_d   = res_q;
            done_d  = done_q;
            unexp_d = unexp_q;
            extra_d = extra_q;
            vld_d   = 1'b0;
            pixel_d = pixel_q;
            data_d  = data_q;
`ifdef CONV_FEED_CTRL_TIMEOUT_EN
            tmo_d     = '0;
            tmo_err_d = tmo_err_q;
`endif
        end

        arst_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            clr_q   <= '0;
            pix_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            unexp_q <= 1'b0;
            extra_q <= 1'b0;
            vld_q   <= 1'b0;
            pixel_q <= '0;
            data_q  <= '0;
            arst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            pix_q   <= pix_d;
            res_q   <= res_d;
            done_q  <= done_d;
            unexp_q <= unexp_d;
            extra_q <= extra_d;
            vld_q   <= vld_d;
            pixel_q <= pixel_d;
            data_q  <= data_d;
            arst_q  <= arst_d;
        end
    end

`ifdef CONV_FEED_CTRL_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`endif

    assign acc_rst_n = arst_q & ~abort;
    assign acc_valid = vld_q;
    assign acc_pixel = pixel_q;
    assign res_data  = data_q;
    assign status    = pack_status(state_q, pix_q, res_q, done_q,
                                   unexp_q, extra_q, tmo_flag);

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Directed bench for conv_feed_ctrl: pixel strobes checked by a
// scoreboard monitor, status/outputs checked inline.
module tb_conv_feed_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] cmd_in;
    logic        acc_rst_n;
    logic        acc_valid;
    logic [7:0]  acc_pixel;
    logic [31:0] acc_res;
    logic        acc_res_valid;
    logic [31:0] res_data;
    logic [31:0] status;

    typedef struct {
        int         cyc;
        logic [7:0] px;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    conv_feed_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cmd_in        (cmd_in),
        .acc_rst_n     (acc_rst_n),
        .acc_valid     (acc_valid),
        .acc_pixel     (acc_pixel),
        .acc_res       (acc_res),
        .acc_res_valid (acc_res_valid),
        .res_data      (res_data),
        .status        (status)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: every acc_valid must match the oldest expected strobe
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (acc_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stray_valid: acc_valid=1 pixel=%0h at cycle %0d, none expected",
                         acc_pixel, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.px !== acc_pixel) begin
                    n_fail++;
                    $display("FAIL pix_strobe: got pixel %0h at cycle %0d, expected %0h at cycle %0d",
                             acc_pixel, cyc, e.px, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_px(input logic [7:0] px, input bit fwd);
        exp_t e;
        cmd_in[7:0] = px;
        cmd_in[8]   = ~cmd_in[8];
        if (fwd) begin
            e.cyc = cyc + 1;
            e.px  = px;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic result(input logic [31:0] v);
        acc_res       = v;
        acc_res_valid = 1'b1;
        tick();
        acc_res_valid = 1'b0;
    endtask

    task automatic start_and_clear();
        cmd_in[9] = ~cmd_in[9];
        tick();
        chk("start_pix0", {22'd0, status[12:3]}, 32'd0);
        chk("start_res0", {22'd0, status[22:13]}, 32'd0);
        chk("start_flags0", {28'd0, status[26:23]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("clear_rst_low", {31'd0, acc_rst_n}, 32'd0);
            chk("clear_state", {29'd0, status[2:0]}, 32'd1);
            tick();
        end
        chk("load_rst_high", {31'd0, acc_rst_n}, 32'd1);
        chk("load_state", {29'd0, status[2:0]}, 32'd2);
    endtask

    task automatic load_frame(input int n);
        for (int i = 0; i < n; i++) begin
            write_px(8'(i % 256), 1'b1);
        end
    endtask

    task automatic full_frame();
        start_and_clear();
        load_frame(784);
        chk("drain_state", {29'd0, status[2:0]}, 32'd3);
        chk("pix_784", {22'd0, status[12:3]}, 32'd784);
        // result lands in the same cycle as the 784th strobe
        result(32'd0);
        chk("coinc_res", {22'd0, status[22:13]}, 32'd1);
        chk("coinc_pix", {22'd0, status[12:3]}, 32'd784);
        chk("coinc_state", {29'd0, status[2:0]}, 32'd3);
        for (int n = 1; n < 675; n++) begin
            result(n);
        end
        chk("pre_done_state", {29'd0, status[2:0]}, 32'd3);
        chk("pre_done_res", {22'd0, status[22:13]}, 32'd675);
        result(32'd675);
        chk("done_state", {29'd0, status[2:0]}, 32'd4);
        chk("done_flag", {31'd0, status[23]}, 32'd1);
        chk("res_cnt", {22'd0, status[22:13]}, 32'd676);
        chk("res_data", res_data, 32'd675);
        chk("pixel_hold", {24'd0, acc_pixel}, 32'd15);
    endtask

    initial begin
        int k;
        sys_rst_n     = 1'b0;
        cmd_in        = '0;
        acc_res       = '0;
        acc_res_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_acc_rst_n", {31'd0, acc_rst_n}, 32'd0);
        chk("rst_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_pixel", {24'd0, acc_pixel}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_status", status, 32'd0);
        sys_rst_n = 1'b1;
        #1;
        chk("rel_before_edge", {31'd0, acc_rst_n}, 32'd0);
        tick();
        chk("rel_first_edge", {31'd0, acc_rst_n}, 32'd1);

        // Write toggle while idle
        write_px(8'h55, 1'b0);
        chk("idle_no_valid", {31'd0, acc_valid}, 32'd0);
        chk("idle_unexp", {31'd0, status[24]}, 32'd1);
        chk("idle_state", {29'd0, status[2:0]}, 32'd0);

        // Nominal frame (start also clears err_unexp)
        full_frame();

        // Stray traffic after DONE
        write_px(8'hAA, 1'b0);
        chk("done_unexp", {31'd0, status[24]}, 32'd1);
        result(32'd999);
        chk("done_extra", {31'd0, status[25]}, 32'd1);
        chk("done_res_keep", res_data, 32'd675);

        // Abort after 100 pixels
        start_and_clear();
        load_frame(100);
        cmd_in[10] = 1'b1;
        #1;
        chk("abort_rst_now", {31'd0, acc_rst_n}, 32'd0);
        tick();
        chk("abort_state", {29'd0, status[2:0]}, 32'd0);
        chk("abort_rst", {31'd0, acc_rst_n}, 32'd0);
        chk("abort_pix", {22'd0, status[12:3]}, 32'd100);
        tick();
        tick();
        chk("abort_hold_rst", {31'd0, acc_rst_n}, 32'd0);
        chk("abort_hold_pix", {22'd0, status[12:3]}, 32'd100);
        cmd_in[10] = 1'b0;
        #1;
        chk("abort_release", {31'd0, acc_rst_n}, 32'd1);
        tick();

        // Only 10 results come back
        start_and_clear();
        load_frame(784);
        for (int n = 0; n < 10; n++) begin
            result(100 + n);
        end
`ifdef CONV_FEED_CTRL_TIMEOUT_EN
        k = 0;
        while (status[2:0] != 3'd4 && k < 70000) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 32'd65535);
        chk("tmo_flag", {31'd0, status[26]}, 32'd1);
        chk("tmo_done", {31'd0, status[23]}, 32'd1);
        chk("tmo_res_data", res_data, 32'd109);
`else
        k = 0;
        repeat (300) begin
            tick();
            k++;
        end
        chk("wait_state", {29'd0, status[2:0]}, 32'd3);
        chk("wait_no_tmo", {31'd0, status[26]}, 32'd0);
        chk("wait_res", {22'd0, status[22:13]}, 32'd10);
        cmd_in[9] = ~cmd_in[9];
        tick();
        chk("drain_start_ign", {29'd0, status[2:0]}, 32'd3);
        cmd_in[10] = 1'b1;
        tick();
        cmd_in[10] = 1'b0;
        chk("wait_abort", {29'd0, status[2:0]}, 32'd0);
`endif

        // Reset mid-LOAD
        start_and_clear();
        load_frame(50);
        sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_acc_rst_n", {31'd0, acc_rst_n}, 32'd0);
        chk("mid_rst_valid", {31'd0, acc_valid}, 32'd0);
        chk("mid_rst_pixel", {24'd0, acc_pixel}, 32'd0);
        chk("mid_rst_res_data", res_data, 32'd0);
        chk("mid_rst_status", status, 32'd0);
        cmd_in[9] = ~cmd_in[9];
        tick();
        tick();
        chk("rst_start_ign", status, 32'd0);
        chk("rst_start_rst_n", {31'd0, acc_rst_n}, 32'd0);
        cmd_in    = '0;
        sys_rst_n = 1'b1;
        tick();
        chk("post_rst_rst_n", {31'd0, acc_rst_n}, 32'd1);
        tick();
        chk("post_rst_status", status, 32'd0);
        full_frame();

        repeat (2) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
